// File: rtl/mips_mem_pkg.sv
// Shared definitions for the MIPS data-memory responder.
// This package holds the FSM state encoding, the byte-enable width and the word-alignment mask.
package mips_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int          BE_W            = 4;
    localparam logic [31:0] WORD_ALIGN_MASK = 32'h0000_0003;

endpackage

// File: rtl/dmem_array.sv
// Word storage of 2**ADDR_WIDTH x 32 bits.
// Writes are synchronous with per-byte-lane enables; reads are combinational.
module dmem_array
    import mips_mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [BE_W-1:0]       be,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata
);

    logic [31:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        for (int i = 0; i < BE_W; i++) begin
            if (we && be[i]) begin
                mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder for the MIPS load/store port.
// It accepts one request at a time, applies a fixed access latency and returns data or an error.
module dmem_responder
    import mips_mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int LATENCY    = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [31:0]     req_addr,
    input  logic [31:0]     req_wdata,
    input  logic [BE_W-1:0] req_be,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [31:0]     resp_rdata,
    output logic            resp_err
);

    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    function automatic logic addr_err(input logic [31:0] a);
        return ((a & WORD_ALIGN_MASK) != 32'd0) || ((a >> (ADDR_WIDTH + 2)) != 32'd0);
    endfunction

    state_t            state, state_nxt;
    logic [3:0]        cnt;
    logic              accept, do_access;

    logic              lat_we;
    logic [31:0]       lat_addr, lat_wdata;
    logic [BE_W-1:0]   lat_be;

    logic              acc_we, acc_err;
    logic [31:0]       acc_addr, acc_wdata;
    logic [BE_W-1:0]   acc_be;
    logic [31:0]       rd_word;

    // The accept edge counts as the first latency edge, so a counter that reaches zero triggers the access.
    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        accept    = 1'b0;
        do_access = 1'b0;
        case (state)
            IDLE: begin
                req_ready = ~reset;
                if (req_valid && !reset) begin
                    accept = 1'b1;
                    if (LATENCY == 1) begin
                        do_access = 1'b1;
                        state_nxt = RESP;
                    end else begin
                        state_nxt = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt <= 4'd1) begin
                    do_access = 1'b1;
                    state_nxt = RESP;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // The access uses the live request when LATENCY is 1 and the latched request otherwise.
    always_comb begin
        if (state == IDLE) begin
            acc_we    = req_we;
            acc_addr  = req_addr;
            acc_wdata = req_wdata;
            acc_be    = req_be;
        end else begin
            acc_we    = lat_we;
            acc_addr  = lat_addr;
            acc_wdata = lat_wdata;
            acc_be    = lat_be;
        end
        acc_err = addr_err(acc_addr);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            resp_rdata <= 32'd0;
            resp_err   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                cnt <= CNT_LOAD;
            end else if (state == WAIT && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            if (do_access) begin
                resp_rdata <= (acc_we || acc_err) ? 32'd0 : rd_word;
                resp_err   <= acc_err;
            end else if (state == RESP && resp_ready) begin
                resp_rdata <= 32'd0;
                resp_err   <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            lat_we    <= req_we;
            lat_addr  <= req_addr;
            lat_wdata <= req_wdata;
            lat_be    <= req_be;
        end
    end

    assign resp_valid = (state == RESP);

    dmem_array #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_array (
        .clk   (clk),
        .we    (do_access & acc_we & ~acc_err),
        .be    (acc_be),
        .addr  (acc_addr[ADDR_WIDTH+1:2]),
        .wdata (acc_wdata),
        .rdata (rd_word)
    );

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: four instances with LATENCY 2, 3, 1 and 15 share clock and reset.
// Expected values are hand-computed constants.
module tb_dmem_responder;

    localparam int N = 4;
    localparam int LATS [N] = '{2, 3, 1, 15};

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid  [N];
    logic        req_ready  [N];
    logic        req_we     [N];
    logic [31:0] req_addr   [N];
    logic [31:0] req_wdata  [N];
    logic [3:0]  req_be     [N];
    logic        resp_valid [N];
    logic        resp_ready [N];
    logic [31:0] resp_rdata [N];
    logic        resp_err   [N];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        dmem_responder #(
            .ADDR_WIDTH(8),
            .LATENCY   (LATS[g])
        ) u_dut (
            .clk        (clk),
            .reset      (reset),
            .req_valid  (req_valid[g]),
            .req_ready  (req_ready[g]),
            .req_we     (req_we[g]),
            .req_addr   (req_addr[g]),
            .req_wdata  (req_wdata[g]),
            .req_be     (req_be[g]),
            .resp_valid (resp_valid[g]),
            .resp_ready (resp_ready[g]),
            .resp_rdata (resp_rdata[g]),
            .resp_err   (resp_err[g])
        );
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One complete transaction with resp_ready held high; it returns in IDLE, #1 after an edge.
    task automatic xact(input int d, input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, output logic [31:0] rdata, output logic err, output int lat);
        int   waitc = 0;
        logic tmo   = 1'b0;
        req_we[d]    = we;
        req_addr[d]  = addr;
        req_wdata[d] = wdata;
        req_be[d]    = be;
        req_valid[d] = 1'b1;
        @(negedge clk);
        while (!req_ready[d] && waitc < 50) begin
            @(negedge clk);
            waitc++;
        end
        @(posedge clk);
        #1;
        req_valid[d] = 1'b0;
        lat = 1;
        while (!resp_valid[d] && !tmo) begin
            @(posedge clk);
            #1;
            lat++;
            if (lat > 40) tmo = 1'b1;
        end
        check("xact_timeout", 32'(tmo), 32'd0);
        rdata = resp_rdata[d];
        err   = resp_err[d];
        @(posedge clk);
        #1;
    endtask

    task automatic sweep(input int d);
        logic [31:0] rd;
        logic        er;
        int          lat;
        int          acc[$];
        int          rv  = -1;
        int          cyc = 0;
        logic        a;
        xact(d, 1'b1, 32'h08, 32'h600D_F00D, 4'hF, rd, er, lat);
        check($sformatf("sweep%0d_store_lat", LATS[d]), 32'(lat), 32'(LATS[d]));
        req_we[d]    = 1'b0;
        req_addr[d]  = 32'h08;
        req_valid[d] = 1'b1;
        while (acc.size() < 2 && cyc < 100) begin
            @(negedge clk);
            a = req_ready[d];
            @(posedge clk);
            cyc++;
            if (a) acc.push_back(cyc);
            #1;
            if (resp_valid[d] && rv < 0) begin
                rv = cyc;
                check($sformatf("sweep%0d_rdata", LATS[d]), resp_rdata[d], 32'h600D_F00D);
            end
        end
        req_valid[d] = 1'b0;
        check($sformatf("sweep%0d_accepts", LATS[d]), 32'(acc.size()), 32'd2);
        if (acc.size() == 2) begin
            check($sformatf("sweep%0d_acc2acc", LATS[d]), 32'(acc[1] - acc[0]), 32'(LATS[d] + 1));
            check($sformatf("sweep%0d_acc2resp", LATS[d]), 32'(rv - acc[0] + 1), 32'(LATS[d]));
        end
        repeat (LATS[d] + 2) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;
        for (int i = 0; i < N; i++) begin
            req_valid[i]  = 1'b0;
            req_we[i]     = 1'b0;
            req_addr[i]   = 32'd0;
            req_wdata[i]  = 32'd0;
            req_be[i]     = 4'h0;
            resp_ready[i] = 1'b1;
        end
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_req_ready", 32'(req_ready[0]), 32'd0);
        check("rst_resp_valid", 32'(resp_valid[0]), 32'd0);
        check("rst_resp_rdata", resp_rdata[0], 32'd0);
        check("rst_resp_err", 32'(resp_err[0]), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("idle_req_ready", 32'(req_ready[0]), 32'd1);

        // Single store/load round trip on LATENCY=2
        xact(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, rd, er, lat);
        check("st10_lat", 32'(lat), 32'd2);
        check("st10_rdata", rd, 32'd0);
        check("st10_err", 32'(er), 32'd0);
        xact(0, 1'b0, 32'h10, 32'd0, 4'h0, rd, er, lat);
        check("ld10_lat", 32'(lat), 32'd2);
        check("ld10_rdata", rd, 32'hDEAD_BEEF);
        check("ld10_err", 32'(er), 32'd0);

        // Byte merge, plus an all-lanes-off store that must change nothing
        xact(0, 1'b1, 32'h20, 32'h1122_3344, 4'hF, rd, er, lat);
        xact(0, 1'b1, 32'h20, 32'hAABB_CCDD, 4'b0101, rd, er, lat);
        xact(0, 1'b1, 32'h20, 32'hFFFF_FFFF, 4'b0000, rd, er, lat);
        check("be0_err", 32'(er), 32'd0);
        xact(0, 1'b0, 32'h20, 32'd0, 4'hF, rd, er, lat);
        check("merge_rdata", rd, 32'h11BB_33DD);

        // Misaligned and out-of-range requests
        xact(0, 1'b0, 32'h13, 32'd0, 4'hF, rd, er, lat);
        check("mis_err", 32'(er), 32'd1);
        check("mis_rdata", rd, 32'd0);
        xact(0, 1'b1, 32'h00, 32'h0123_4567, 4'hF, rd, er, lat);
        xact(0, 1'b1, 32'h400, 32'hFFFF_FFFF, 4'hF, rd, er, lat);
        check("oor_err", 32'(er), 32'd1);
        check("oor_rdata", rd, 32'd0);
        xact(0, 1'b0, 32'h00, 32'd0, 4'hF, rd, er, lat);
        check("oor_nowrite", rd, 32'h0123_4567);
        check("oor_follow_err", 32'(er), 32'd0);

        // Backpressure: response held for 5 cycles while a second request waits
        resp_ready[0] = 1'b0;
        req_we[0]     = 1'b0;
        req_addr[0]   = 32'h10;
        req_valid[0]  = 1'b1;
        @(posedge clk);
        #1;
        req_addr[0] = 32'h20;
        @(posedge clk);
        #1;
        check("bp_valid_rise", 32'(resp_valid[0]), 32'd1);
        repeat (5) begin
            @(posedge clk);
            #1;
            check("bp_valid_hold", 32'(resp_valid[0]), 32'd1);
            check("bp_rdata_hold", resp_rdata[0], 32'hDEAD_BEEF);
            check("bp_req_ready", 32'(req_ready[0]), 32'd0);
        end
        resp_ready[0] = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release_valid", 32'(resp_valid[0]), 32'd0);
        check("bp_release_rdata", resp_rdata[0], 32'd0);
        check("bp_release_ready", 32'(req_ready[0]), 32'd1);
        @(posedge clk);
        #1;
        req_valid[0] = 1'b0;
        check("bp_accept_ready", 32'(req_ready[0]), 32'd0);
        @(posedge clk);
        #1;
        check("bp_second_valid", 32'(resp_valid[0]), 32'd1);
        check("bp_second_rdata", resp_rdata[0], 32'h11BB_33DD);
        @(posedge clk);
        #1;

        // Reset in WAIT on LATENCY=3 aborts the store
        xact(1, 1'b1, 32'h30, 32'h0BAD_BEEF, 4'hF, rd, er, lat);
        check("l3_store_lat", 32'(lat), 32'd3);
        req_we[1]    = 1'b1;
        req_addr[1]  = 32'h30;
        req_wdata[1] = 32'hCAFE_F00D;
        req_be[1]    = 4'hF;
        req_valid[1] = 1'b1;
        @(posedge clk);
        #1;
        req_valid[1] = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("midwait_valid_rst", 32'(resp_valid[1]), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (4) begin
            @(posedge clk);
            #1;
            check("midwait_no_resp", 32'(resp_valid[1]), 32'd0);
        end
        xact(1, 1'b0, 32'h30, 32'd0, 4'hF, rd, er, lat);
        check("midwait_prior", rd, 32'h0BAD_BEEF);

        // Latency sweep at the range limits
        sweep(2);
        sweep(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
